// File: rtl/mul_issue_queue.sv
// Operand FIFO in front of the combinational multiplier, with a
// registered valid/ready product stage behind it.
module mul_issue_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNTW  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   input  logic [WIDTH-1:0] mul_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [CNTW-1:0]  count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

   logic [2*WIDTH-1:0] storage [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic               push;
   logic               fire;
   logic               not_empty;

   assign not_empty = (count != '0);
   assign in_ready  = (count != FULL);
   assign push      = in_valid & in_ready;
   assign fire      = not_empty & (~out_valid | out_ready);

   // Gate the head onto the multiplier only when it holds live data
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (not_empty) begin
         mul_a = storage[rd_ptr][2*WIDTH-1:WIDTH];
         mul_b = storage[rd_ptr][WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         storage[wr_ptr] <= {in1, in2};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (fire) begin
            rd_ptr     <= rd_ptr + PW'(1);
            out_result <= mul_result;
            out_valid  <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         unique case ({push, fire})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_issue_queue.sv
// Directed bench for mul_issue_queue; the multiplier beside the DUT is
// modelled here as a plain combinational product.
module tb_mul_issue_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CNTW  = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [WIDTH-1:0] mul_result;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [CNTW-1:0]  count;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign mul_result = mul_a * mul_b;

   mul_issue_queue #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .CNTW (CNTW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_result(mul_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .count     (count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int a, input int b);
      in_valid = v;
      in1      = a;
      in2      = b;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      vectors++;
      if ({out_valid, out_result, count, in_ready, mul_a, mul_b}
          !== {1'b0, 32'd0, 3'd0, 1'b1, 32'd0, 32'd0}) begin
         miscompares++;
         $display("FAIL reset_async: ov=%0b res=%0d cnt=%0d rdy=%0b a=%0d b=%0d",
                  out_valid, out_result, count, in_ready, mul_a, mul_b);
      end
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         if ({out_valid, out_result, count, in_ready, mul_a}
             !== {1'b0, 32'd0, 3'd0, 1'b1, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_idle%0d: ov=%0b res=%0d cnt=%0d rdy=%0b a=%0d",
                     i, out_valid, out_result, count, in_ready, mul_a);
         end
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      drive(1'b1, 2, 3);
      step();
      drive(1'b0, 0, 0);
      vectors++;
      if ({count, mul_a, mul_b, out_valid} !== {3'd1, 32'd2, 32'd3, 1'b0}) begin
         miscompares++;
         $display("FAIL single_head: cnt=%0d a=%0d b=%0d ov=%0b exp 1 2 3 0",
                  count, mul_a, mul_b, out_valid);
      end
      step();
      vectors++;
      if ({out_valid, out_result, count} !== {1'b1, 32'd6, 3'd0}) begin
         miscompares++;
         $display("FAIL single_result: ov=%0b res=%0d cnt=%0d exp 1 6 0",
                  out_valid, out_result, count);
      end
      step();
      vectors++;
      if ({out_valid, mul_a} !== {1'b0, 32'd0}) begin
         miscompares++;
         $display("FAIL single_drain: ov=%0b a=%0d exp 0 0", out_valid, mul_a);
      end
   endtask

   task automatic test_stream();
      int a [5] = '{1, 6, 5, 10, 10};
      int b [5] = '{3, 2, 9, 10, 6};
      int e [5] = '{3, 12, 45, 100, 60};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) drive(1'b1, a[i], b[i]);
         else drive(1'b0, 0, 0);
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_ready%0d: got %0b exp 1", i, in_ready);
         end
         step();
         vectors++;
         if (count > 3'd1) begin
            miscompares++;
            $display("FAIL stream_count%0d: got %0d exp <=1", i, count);
         end
         if (i > 0) begin
            vectors++;
            if ({out_valid, out_result} !== {1'b1, 32'(e[i-1])}) begin
               miscompares++;
               $display("FAIL stream_out%0d: ov=%0b res=%0d exp 1 %0d",
                        i, out_valid, out_result, e[i-1]);
            end
         end
      end
      drive(1'b0, 0, 0);
      step();
   endtask

   task automatic test_backpressure();
      int a [6] = '{2, 1, 6, 5, 10, 10};
      int b [6] = '{3, 3, 2, 9, 10, 6};
      int e [5] = '{3, 12, 45, 100, 60};
      int ec [5] = '{3, 3, 2, 1, 0};
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, a[i], b[i]);
         step();
      end
      vectors++;
      if ({count, in_ready, out_valid, out_result}
          !== {3'd4, 1'b0, 1'b1, 32'd6}) begin
         miscompares++;
         $display("FAIL full: cnt=%0d rdy=%0b ov=%0b res=%0d exp 4 0 1 6",
                  count, in_ready, out_valid, out_result);
      end
      drive(1'b1, a[5], b[5]);
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         if ({count, in_ready, out_result} !== {3'd4, 1'b0, 32'd6}) begin
            miscompares++;
            $display("FAIL full_hold%0d: cnt=%0d rdy=%0b res=%0d exp 4 0 6",
                     i, count, in_ready, out_result);
         end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 1) drive(1'b0, 0, 0);
         vectors++;
         if ({out_valid, out_result, count}
             !== {1'b1, 32'(e[i]), 3'(ec[i])}) begin
            miscompares++;
            $display("FAIL drain%0d: ov=%0b res=%0d cnt=%0d exp 1 %0d %0d",
                     i, out_valid, out_result, count, e[i], ec[i]);
         end
      end
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_end: ov=%0b exp 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int a [6] = '{3, 7, 2, 11, 8, 65536};
      int b [6] = '{4, 7, 9, 5, 8, 65537};
      int e [6] = '{12, 49, 18, 55, 64, 65536};
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, a[i], b[i]);
         step();
      end
      vectors++;
      if ({count, out_valid, out_result} !== {3'd2, 1'b1, 32'd12}) begin
         miscompares++;
         $display("FAIL b2b_setup: cnt=%0d ov=%0b res=%0d exp 2 1 12",
                  count, out_valid, out_result);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive(1'b1, a[i+3], b[i+3]);
         else drive(1'b0, 0, 0);
         step();
         vectors++;
         if ({out_valid, out_result} !== {1'b1, 32'(e[i+1])}) begin
            miscompares++;
            $display("FAIL b2b_out%0d: ov=%0b res=%0d exp 1 %0d",
                     i, out_valid, out_result, e[i+1]);
         end
         if (i < 3) begin
            vectors++;
            if (count !== 3'd2) begin
               miscompares++;
               $display("FAIL b2b_count%0d: got %0d exp 2", i, count);
            end
         end
      end
      drive(1'b0, 0, 0);
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 7 + i, 3);
         step();
      end
      drive(1'b0, 0, 0);
      vectors++;
      if ({count, out_valid} !== {3'd3, 1'b1}) begin
         miscompares++;
         $display("FAIL mid_setup: cnt=%0d ov=%0b exp 3 1", count, out_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if ({count, out_valid, out_result, in_ready, mul_a}
          !== {3'd0, 1'b0, 32'd0, 1'b1, 32'd0}) begin
         miscompares++;
         $display("FAIL mid_reset: cnt=%0d ov=%0b res=%0d rdy=%0b a=%0d",
                  count, out_valid, out_result, in_ready, mul_a);
      end
      reset = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 5, 9);
      step();
      drive(1'b0, 0, 0);
      vectors++;
      if ({count, out_valid, mul_a, mul_b}
          !== {3'd1, 1'b0, 32'd5, 32'd9}) begin
         miscompares++;
         $display("FAIL mid_push: cnt=%0d ov=%0b a=%0d b=%0d exp 1 0 5 9",
                  count, out_valid, mul_a, mul_b);
      end
      step();
      vectors++;
      if ({out_valid, out_result, count} !== {1'b1, 32'd45, 3'd0}) begin
         miscompares++;
         $display("FAIL mid_result: ov=%0b res=%0d cnt=%0d exp 1 45 0",
                  out_valid, out_result, count);
      end
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_stale: ov=%0b res=%0d exp ov 0",
                  out_valid, out_result);
      end
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 0, 0);
      step();
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul_issue_queue.md
Name: mul_issue_queue

Overview:
Operand-buffering and result-capture stage that sits directly around the combinational 32-bit multiplier (MUL). Upstream logic pushes operand pairs through a valid/ready handshake. The block queues them, drives the head pair onto the multiplier inputs, and registers each product into an output register with valid/ready. The multiplier is instantiated beside this block at the top level and is not instantiated inside it.

Parameters:
WIDTH, 32, operand and result width; matches MUL in1/in2/Result
DEPTH, 4, operand-queue entries; power of two, minimum 2
CNTW, 3, count width; must hold the value DEPTH (log2(DEPTH)+1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream offers an operand pair
in_ready  output  1  queue can accept a pair this cycle
in1  input  WIDTH  first operand
in2  input  WIDTH  second operand
mul_a  output  WIDTH  to MUL in1
mul_b  output  WIDTH  to MUL in2
mul_result  input  WIDTH  from MUL Result (combinational product of mul_a, mul_b)
out_valid  output  1  out_result holds an unconsumed product
out_ready  input  1  downstream accepts the product
out_result  output  WIDTH  registered product
count  output  CNTW  entries currently queued (excludes the output register)

Behaviour:
- Reset (async assert, synchronous-style deassert at the next clk edge):
  - count=0; read and write pointers=0; out_valid=0; out_result=0.
  - Queue storage is not cleared.
- Reset mid-operation discards all queued pairs and any pending product. No partial state survives.
- push = in_valid & in_ready.
  - in_ready = (count != DEPTH). It is purely registered-state driven and has no combinational path from out_ready.
- On push: storage[wr_ptr] <= {in1,in2}; wr_ptr increments mod DEPTH (wraps DEPTH-1 -> 0).
- mul_a/mul_b = storage[rd_ptr] when count != 0, else 0. This avoids toggling MUL on stale data.
- fire = (count != 0) & (!out_valid | out_ready).
- On fire:
  - out_result <= mul_result;
  - out_valid <= 1;
  - rd_ptr increments mod DEPTH.
- If !fire and out_valid & out_ready: out_valid <= 0; out_result holds its last value.
- count next-state:
  - +1 on push only;
  - -1 on fire only;
  - unchanged on both or neither.
- Full queue: in_ready=0. A pair offered while full is not accepted; upstream must hold in1/in2/in_valid.
- Push into an empty queue: the entry becomes the head at the next edge. It fires no earlier than that edge, so the product appears one cycle after acceptance.
- Throughput: one product per cycle when in_valid and out_ready are held high.
- Ordering: strict FIFO. Products leave in acceptance order.
- Arithmetic: no width change inside this block.
  - out_result is exactly mul_result, i.e. the low WIDTH bits of the product as MUL produces them.
  - Overflow is not flagged.
- Backpressure: with out_valid=1 and out_ready=0, out_result is stable and no pop occurs. The queue keeps filling until full.
- Simultaneous push and fire with count=DEPTH: impossible, since in_ready=0. With count=0: fire cannot occur that cycle.

Test Plan:
- Reset and idle: assert reset mid-cycle.
  - Required: out_valid=0, out_result=0, count=0, in_ready=1, mul_a=mul_b=0 immediately (async).
  - After release with no input, all stay at these values.
- Single op: push (2,3) at edge N with out_ready=1.
  - At edge N: count=1, mul_a=2, mul_b=3.
  - At edge N+1: out_valid=1, out_result=6, count=0.
  - At edge N+2: out_valid=0.
- Streaming: push (1,3),(6,2),(5,9),(10,10),(10,6) on consecutive cycles, out_ready=1.
  - Required: out_result 3,12,45,100,60 on five consecutive cycles.
  - count never exceeds 1; in_ready stays 1 throughout.
- Backpressure and full: out_ready=0; push (2,3),(1,3),(6,2),(5,9),(10,10),(10,6).
  - Required: out_result=6 held stable; count reaches 4; in_ready=0.
  - (10,6) is not accepted and stays held by upstream.
  - Then raise out_ready: outputs 6,3,12,45,100,60 in order.
  - Write and read pointers wrap correctly.
- Simultaneous push/pop: with count=2 and out_valid=1, assert in_valid and out_ready together for 3 cycles.
  - Required: count stays 2; products remain in FIFO order.
- Reset mid-stream: with count=3 and out_valid=1, pulse reset.
  - Required: everything clears; the next push (5,9) yields out_result=45 one cycle later.
  - No stale product appears.
